// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core widths, ALU op encoding and control bundle
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_NOR = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9,
    ALU_SRA = 4'd10,
    ALU_LUI = 4'd11
  } alu_op_t;

  // All-zero is a bubble: nothing written, no memory access
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

endpackage

// File: rtl/id_ex_if.sv
// rtl/id_ex_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int CNT_W  = 16
);
  import mips_pkg::*;

  logic              flush;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  alu_op_t           id_alu_op;
  logic              id_reg_write, id_mem_read, id_mem_write;
  logic              id_mem_to_reg, id_alu_src, id_reg_dst;

  logic [REG_W-1:0]  ex_rs, ex_rt, ex_dst;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  alu_op_t           ex_alu_op;
  logic              ex_reg_write, ex_mem_read, ex_mem_write;
  logic              ex_mem_to_reg, ex_alu_src;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output flush, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
    input  ex_rs, ex_rt, ex_dst, ex_rs_data, ex_rt_data, ex_imm, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
           stall, stall_count
  );

  modport slave (
    input  flush, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
    output ex_rs, ex_rt, ex_dst, ex_rs_data, ex_rt_data, ex_imm, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
           stall, stall_count
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard: load in EX feeds ID source
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hz
);

  // $zero is never a real producer
  assign hz = ex_mem_read & (ex_dst != '0) & ((ex_dst == id_rs) | (ex_dst == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and bubble counter
// Optional feature macro: LOAD_USE_STALL_EN (hazard stall + stall_count); otherwise flush-only bubbles.
module id_ex_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int CNT_W  = 16
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);
  import mips_pkg::*;

`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic  hz;
  logic  bubble;
  ctrl_t id_ctrl;
  ctrl_t cap_ctrl;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_dst      (bus.ex_dst),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .hz          (hz)
  );

  // Flush wins over the hazard: a squashed instruction is never held
  assign bus.stall = STALL_EN & hz & ~bus.flush;
  assign bubble    = bus.flush | (STALL_EN & hz);

  assign id_ctrl = '{
    reg_write:  bus.id_reg_write,
    mem_read:   bus.id_mem_read,
    mem_write:  bus.id_mem_write,
    mem_to_reg: bus.id_mem_to_reg,
    alu_src:    bus.id_alu_src,
    reg_dst:    bus.id_reg_dst
  };
  assign cap_ctrl = bubble ? ctrl_t'('0) : id_ctrl;

  // Index/data fields load ID values even on a bubble; they are don't-care there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_rs         <= {REG_W{1'b0}};
      bus.ex_rt         <= {REG_W{1'b0}};
      bus.ex_dst        <= {REG_W{1'b0}};
      bus.ex_rs_data    <= {DATA_W{1'b0}};
      bus.ex_rt_data    <= {DATA_W{1'b0}};
      bus.ex_imm        <= {DATA_W{1'b0}};
      bus.ex_alu_op     <= ALU_NOP;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      bus.ex_alu_src    <= 1'b0;
    end else begin
      bus.ex_rs         <= bus.id_rs;
      bus.ex_rt         <= bus.id_rt;
      bus.ex_dst        <= cap_ctrl.reg_dst ? bus.id_rd : bus.id_rt;
      bus.ex_rs_data    <= bus.id_rs_data;
      bus.ex_rt_data    <= bus.id_rt_data;
      bus.ex_imm        <= bus.id_imm;
      bus.ex_alu_op     <= bubble ? ALU_NOP : bus.id_alu_op;
      bus.ex_reg_write  <= cap_ctrl.reg_write;
      bus.ex_mem_read   <= cap_ctrl.mem_read;
      bus.ex_mem_write  <= cap_ctrl.mem_write;
      bus.ex_mem_to_reg <= cap_ctrl.mem_to_reg;
      bus.ex_alu_src    <= cap_ctrl.alu_src;
    end
  end

`ifdef LOAD_USE_STALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall_count <= {CNT_W{1'b0}};
    end else if (bus.stall && (bus.stall_count != {CNT_W{1'b1}})) begin
      bus.stall_count <= bus.stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between ID and EX of the 5-stage MIPS core, combined with load-use hazard detection. It captures decoded operands and control from ID each cycle and presents them to EX and to the forwarding unit as `rs`/`rt`. When a load in EX is followed by a dependent instruction in ID, it stalls PC/IF-ID and inserts a one-cycle bubble. It also counts inserted load-use bubbles for performance monitoring.

## Interface
- `DATA_W`, 32, operand/immediate width
- `REG_W`, 5, register index width
- `CNT_W`, 16, stall counter width
---
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  squash the ID instruction (branch/jump taken)
- `id_rs`, `id_rt`, `id_rd`  in  REG_W  decoded register indices
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_alu_op`  in  4  ALU operation
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_alu_src`, `id_reg_dst`  in  1  control bits
- `ex_rs`, `ex_rt`  out  REG_W  registered sources (to forwarding unit)
- `ex_dst`  out  REG_W  registered destination: `id_reg_dst ? id_rd : id_rt`
- `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  DATA_W  registered operands
- `ex_alu_op`  out  4; `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_alu_src`  out  1  registered control
- `stall`  out  1  combinational; hold PC and IF/ID
- `stall_count`  out  CNT_W  bubbles inserted since reset

## Operation
- Hazard: `hz = ex_mem_read & (ex_dst != 0) & ((ex_dst == id_rs) | (ex_dst == id_rt))`.
- `stall = hz & ~flush`. Flush wins: a squashed instruction never stalls.
- Each rising edge, per cycle class:
  - `flush | hz`: bubble. All registered control bits and `ex_alu_op` load 0. Index/data fields still load ID values (don't-care).
  - otherwise: all fields load ID values; `ex_dst` is muxed at capture.
- `stall_count` increments by 1 on every cycle with `stall`=1 and saturates at all-ones.
- A hazard lasts exactly one cycle: the bubble clears `ex_mem_read`, so `hz` drops in the next cycle and the held ID instruction proceeds.
- Register index 0 never causes a stall.

## Timing
- Register latency is 1 cycle, ID to EX.
- `stall` is combinational from ID inputs and current EX state in the same cycle, with no registered delay.
- Reset (async, active-high) values: all `ex_*` outputs 0, `stall_count` 0. While `rst`=1, `stall`=0 because `ex_mem_read`=0.
- Reset asserted mid-stall clears the pending bubble. The first post-reset edge captures ID normally.
- Back-to-back loads where the second depends on the first: one stall on the dependency, then normal flow.

## Configuration
- `LOAD_USE_STALL_EN` defined: hazard detection, bubble insertion and `stall_count` are active as above.
- Not defined:
  - `stall` is tied 0 and `stall_count` is tied 0.
  - Bubbles come only from `flush`.
  - Software must insert NOPs after loads.

## Structure
- The shared package `mips_pkg` holds:
  - `REG_W`, `DATA_W`
  - the ALU-op encoding typedef, with value 0 = NOP
  - a `ctrl_t` struct of the six control bits, so that bubble = `'0`
- One sub-module is natural: `load_use_detect`, the purely combinational `hz` equation. The register and counter stay in the top.

## Test plan
1. Reset: assert `rst` mid-cycle with nonzero inputs -> all outputs 0 immediately. `stall`=0.
2. Load-use: EX holds lw with `ex_dst`=5; ID presents `id_rs`=5 -> `stall`=1 this cycle, EX control all 0 next edge, `stall_count`=1. The following cycle `stall`=0 and the add enters EX with `ex_rs`=5.
3. $zero: EX lw with `ex_dst`=0; ID `id_rt`=0 -> `stall`=0, normal capture.
4. Flush priority: load-use condition true and `flush`=1 -> `stall`=0, bubble captured, `stall_count` unchanged.
5. Dest mux: `id_reg_dst`=1, `id_rd`=9, `id_rt`=4 -> `ex_dst`=9. With `id_reg_dst`=0 -> `ex_dst`=4.
6. Saturation, run with `CNT_W`=2: force 5 stalls -> `stall_count` reads 3 and holds at 3.
